// File: rtl/sio_phy_pkg.sv
// Shared constants and types for the SIO differential pad front-end model.
// The sample word is the line XORed with a fixed polarity mask.
package sio_phy_pkg;

  localparam int NIB_W  = 4;
  localparam int NSMP_W = 8;

  localparam logic [NSMP_W-1:0] IDLE_LINE = 8'hFF;
  localparam logic [NSMP_W-1:0] SMP_POL   = 8'hAA;
  localparam logic [NSMP_W-1:0] IDLE_O    = 8'h55;
  localparam logic [1:0]        IDLE_BITS = 2'b11;

  typedef struct packed {
    logic             t;
    logic [NIB_W-1:0] td;
  } tx_nib_t;

  typedef enum logic [1:0] {
    SER_IDLE,
    SER_H0,
    SER_H1
  } ser_st_e;

  // Two line bits per cycle, each held for half of the sample instants.
  function automatic logic [NSMP_W-1:0] bits_to_line(input logic [1:0] b);
    return {{(NSMP_W/2){b[1]}}, {(NSMP_W/2){b[0]}}};
  endfunction

endpackage

// File: rtl/sio_phy_oversample.sv
// Two-stage receive pipeline: raw line captured, then polarity-corrected
// so odd (complement receiver) bits come out inverted.
module sio_phy_oversample
  import sio_phy_pkg::*;
#(
  parameter int NSMP = NSMP_W
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NSMP-1:0] line_i,
  output logic [NSMP-1:0] o_o
);

  logic [NSMP-1:0] line_q, o_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      line_q <= IDLE_LINE;
      o_q    <= IDLE_O;
    end else begin
      line_q <= line_i;
      o_q    <= line_q ^ SMP_POL;
    end
  end

  assign o_o = o_q;

endmodule

// File: rtl/sio_phy_model.sv
// SIO pad front end: 4:1 nibble serializer, tristate buffer with loopback,
// and the 8x oversampler feeding the DRU.
module sio_phy_model
  import sio_phy_pkg::*;
#(
  parameter int NIB  = NIB_W,
  parameter int NSMP = NSMP_W
) (
  input  logic            c,
  input  logic            r,
  input  logic            ce,
  input  logic [NIB-1:0]  td,
  input  logic            t,
  input  logic [NSMP-1:0] pad_i,
  output logic [1:0]      line_o,
  output logic            line_oe,
  output logic [NSMP-1:0] o
);

  ser_st_e         st_q, st_d;
  tx_nib_t         nib_q, nib_d;
  logic [1:0]      line_q, line_d;
  logic            oe_q, oe_d;
  logic [NSMP-1:0] line_w;

  always_ff @(posedge c) begin
    if (r) begin
      st_q   <= SER_IDLE;
      nib_q  <= '0;
      line_q <= IDLE_BITS;
      oe_q   <= 1'b0;
    end else begin
      st_q   <= st_d;
      nib_q  <= nib_d;
      line_q <= line_d;
      oe_q   <= oe_d;
    end
  end

  // A new strobe always restarts at half 0, dropping any pending half 1.
  always_comb begin
    st_d   = st_q;
    nib_d  = nib_q;
    line_d = IDLE_BITS;
    oe_d   = oe_q;
    case (st_q)
      SER_H0: begin
        st_d   = SER_H1;
        line_d = nib_q.td[3:2];
        oe_d   = ~nib_q.t;
      end
      SER_H1: begin
        st_d   = SER_IDLE;
        line_d = nib_q.td[1:0];
        oe_d   = ~nib_q.t;
      end
      default: ;
    endcase
    if (ce) begin
      st_d  = SER_H0;
      nib_d = '{t: t, td: td};
    end
  end

  // Receiver always watches the pad, so our own drive loops back.
  assign line_w = oe_q ? bits_to_line(line_q) : pad_i;

  sio_phy_oversample #(.NSMP(NSMP)) u_ovs (
    .clk_i  (c),
    .rst_i  (r),
    .line_i (line_w),
    .o_o    (o)
  );

  assign line_o  = line_q;
  assign line_oe = oe_q;

endmodule

// File: tb/tb_sio_phy_model.sv
// Self-checking bench: directed scenarios against constants, then random
// traffic against a slot-schedule reference model.
module tb_sio_phy_model;

  localparam int NC = 2048;

  logic       c = 1'b0;
  logic       r = 1'b1;
  logic       ce = 1'b0;
  logic [3:0] td = '0;
  logic       t = 1'b0;
  logic [7:0] pad_i = '0;
  logic [1:0] line_o;
  logic       line_oe;
  logic [7:0] o;

  int checks = 0;
  int errors = 0;
  int cyc = 1;

  // Reference model: each strobe books two future line slots; reset voids bookings.
  bit         r_h   [NC];
  bit         sv    [NC];
  logic [1:0] sb    [NC];
  bit         so    [NC];
  logic [1:0] e_line[NC];
  bit         e_oe  [NC];
  logic [7:0] e_o   [NC];
  logic [7:0] line_h[NC];

  sio_phy_model dut (
    .c(c), .r(r), .ce(ce), .td(td), .t(t), .pad_i(pad_i),
    .line_o(line_o), .line_oe(line_oe), .o(o)
  );

  always #5 c = ~c;

  task automatic step(input bit rr, input bit cee, input logic [3:0] tdd,
                      input bit tt, input logic [7:0] pad);
    @(posedge c);
    cyc++;
    #1;
    r = rr; ce = cee; td = tdd; t = tt; pad_i = pad;
    r_h[cyc] = rr;
    if (rr) begin
      for (int j = 1; j <= 3; j++) sv[cyc+j] = 1'b0;
    end else if (cee) begin
      sv[cyc+2] = 1'b1; sb[cyc+2] = tdd[3:2]; so[cyc+2] = ~tt;
      sv[cyc+3] = 1'b1; sb[cyc+3] = tdd[1:0]; so[cyc+3] = ~tt;
    end
    if (sv[cyc]) begin
      e_line[cyc] = sb[cyc];
      e_oe[cyc]   = so[cyc];
    end else begin
      e_line[cyc] = 2'b11;
      e_oe[cyc]   = r_h[cyc-1] ? 1'b0 : e_oe[cyc-1];
    end
    line_h[cyc] = e_oe[cyc] ? {{4{e_line[cyc][1]}}, {4{e_line[cyc][0]}}} : pad;
    e_o[cyc] = (r_h[cyc-1] || r_h[cyc-2]) ? 8'h55 : (line_h[cyc-2] ^ 8'hAA);
    @(negedge c);
  endtask

  task automatic test_reset;
    step(1, 0, 4'h0, 0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step(i < 2, 0, 4'h0, 0, 8'h00);
      if (i < 3) begin
        checks++;
        if (line_o !== 2'b11 || line_oe !== 1'b0) begin
          errors++;
          $display("FAIL reset_tx i=%0d got line_o=%b oe=%b exp 11/0", i, line_o, line_oe);
        end
      end
      checks++;
      if (o !== (i < 4 ? 8'h55 : 8'hAA)) begin
        errors++;
        $display("FAIL reset_o i=%0d got %h exp %h", i, o, (i < 4 ? 8'h55 : 8'hAA));
      end
    end
  endtask

  task automatic test_drive_a;
    for (int i = 0; i < 7; i++) begin
      step(0, i == 0, 4'hA, 0, 8'h00);
      if (i == 2 || i == 3) begin
        checks++;
        if (line_o !== 2'b10 || line_oe !== 1'b1) begin
          errors++;
          $display("FAIL drive_a_tx i=%0d got %b/%b exp 10/1", i, line_o, line_oe);
        end
      end
      if (i == 4) begin
        checks++;
        if (line_o !== 2'b11) begin
          errors++;
          $display("FAIL drive_a_idle got %b exp 11", line_o);
        end
      end
      if (i == 4 || i == 5) begin
        checks++;
        if (o !== 8'h5A) begin
          errors++;
          $display("FAIL drive_a_o i=%0d got %h exp 5a", i, o);
        end
      end
    end
  endtask

  task automatic test_tristate;
    for (int i = 0; i < 6; i++) begin
      step(0, i == 0, 4'h0, 1, (i < 3) ? 8'hF0 : 8'hFF);
      if (i >= 2) begin
        checks++;
        if (line_oe !== 1'b0) begin
          errors++;
          $display("FAIL tristate_oe i=%0d got %b exp 0", i, line_oe);
        end
      end
      if (i >= 4) begin
        checks++;
        if (o !== (i == 4 ? 8'h5A : 8'h55)) begin
          errors++;
          $display("FAIL tristate_o i=%0d got %h exp %h", i, o, (i == 4 ? 8'h5A : 8'h55));
        end
      end
    end
  endtask

  task automatic test_stream;
    logic [1:0] xl[4];
    logic [7:0] xo[4];
    xl = '{2'b00, 2'b01, 2'b00, 2'b10};
    xo = '{8'hAA, 8'hA5, 8'hAA, 8'h5A};
    for (int i = 0; i < 8; i++) begin
      step(0, (i == 0) || (i == 2), (i < 2) ? 4'h1 : 4'h2, 0, 8'h00);
      if (i >= 2 && i < 6) begin
        checks++;
        if (line_o !== xl[i-2] || line_oe !== 1'b1) begin
          errors++;
          $display("FAIL stream_tx i=%0d got %b/%b exp %b/1", i, line_o, line_oe, xl[i-2]);
        end
      end
      if (i >= 4) begin
        checks++;
        if (o !== xo[i-4]) begin
          errors++;
          $display("FAIL stream_o i=%0d got %h exp %h", i, o, xo[i-4]);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] xl[3];
    xl = '{2'b11, 2'b00, 2'b11};
    for (int i = 0; i < 6; i++) begin
      step(0, i < 2, (i == 0) ? 4'hC : 4'h3, 0, 8'h00);
      if (i >= 2 && i < 5) begin
        checks++;
        if (line_o !== xl[i-2] || line_oe !== 1'b1) begin
          errors++;
          $display("FAIL b2b_tx i=%0d got %b/%b exp %b/1", i, line_o, line_oe, xl[i-2]);
        end
      end
      if (i == 5) begin
        checks++;
        if (o !== 8'hAA) begin
          errors++;
          $display("FAIL b2b_o got %h exp aa", o);
        end
      end
    end
  endtask

  task automatic test_mid_reset;
    for (int i = 0; i < 6; i++) begin
      step(i == 2, i == 0, 4'h0, 0, 8'h0F);
      if (i == 2) begin
        checks++;
        if (line_o !== 2'b00 || line_oe !== 1'b1) begin
          errors++;
          $display("FAIL midrst_pre got %b/%b exp 00/1", line_o, line_oe);
        end
      end
      if (i == 3) begin
        checks++;
        if (line_o !== 2'b11 || line_oe !== 1'b0) begin
          errors++;
          $display("FAIL midrst_tx got %b/%b exp 11/0", line_o, line_oe);
        end
      end
      if (i >= 3) begin
        checks++;
        if (o !== (i < 5 ? 8'h55 : 8'hA5)) begin
          errors++;
          $display("FAIL midrst_o i=%0d got %h exp %h", i, o, (i < 5 ? 8'h55 : 8'hA5));
        end
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
           4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
           8'($urandom_range(0, 255)));
      checks++;
      if (line_o !== e_line[cyc] || line_oe !== e_oe[cyc] || o !== e_o[cyc]) begin
        errors++;
        $display("FAIL random cyc=%0d got %b/%b/%h exp %b/%b/%h", cyc,
                 line_o, line_oe, o, e_line[cyc], e_oe[cyc], e_o[cyc]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_drive_a();
    test_tristate();
    test_stream();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
